// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver sample path.
package conv_pkg;

    // Sequencer states for samp_ctrl.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } samp_ctrl_state_t;

    // Default width of dimension and coordinate fields.
    localparam int CONV_DIM_W = 8;

    // Kernel edge length: fill count and window offsets derive from it.
    localparam int CONV_KERNEL = 3;

endpackage : conv_pkg

// File: rtl/samp_ctrl_if.sv
// Column-read port and window-output handshake of samp_ctrl.
// The master side is the sequencer. The slave side is the pixel buffer
// read port, the shift register and the MAC stage.
interface samp_ctrl_if #(
    parameter int DIM_W = 8
);

    // Column read request towards the pixel buffer.
    logic             col_rd_en;
    logic [DIM_W-1:0] col_row;
    logic [DIM_W-1:0] col_col;
    logic             col_rd_valid;

    // Shift strobe towards the sample shift register.
    logic             shift_en;

    // Window presentation towards the MAC stage.
    logic             samp_valid;
    logic             samp_ready;
    logic [DIM_W-1:0] out_row;
    logic [DIM_W-1:0] out_col;

    modport master (
        output col_rd_en, col_row, col_col, shift_en,
        output samp_valid, out_row, out_col,
        input  col_rd_valid, samp_ready
    );

    modport slave (
        input  col_rd_en, col_row, col_col, shift_en,
        input  samp_valid, out_row, out_col,
        output col_rd_valid, samp_ready
    );

endinterface : samp_ctrl_if

// File: rtl/scan_cnt.sv
// Row/column scan counter for samp_ctrl.
// col walks 0..w-1; stepping past w-1 wraps col to 0 and advances row.
// last_row flags the final window row (row == h-3).
module scan_cnt
    import conv_pkg::*;
#(
    parameter int DIM_W = CONV_DIM_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             last_col,
    output logic             last_row
);

    localparam logic [DIM_W-1:0] ONE  = DIM_W'(1);
    localparam logic [DIM_W-1:0] KERN = DIM_W'(CONV_KERNEL);

    assign last_col = (col == (w - ONE));
    assign last_row = (row == (h - KERN));

    // Scan position: clear on frame start, else step in raster order.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, whatever the order of the always blocks.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule : scan_cnt

// File: rtl/samp_ctrl.sv
// Sample shift register sequencer for the AHB convolver.
// It fetches frame columns, strobes the shift register as each column
// returns, and presents each complete 3x3 window with valid/ready.
// Optional build macro SAMP_CTRL_PERF_EN adds a 16-bit saturating
// stall counter output, stall_cnt.
module samp_ctrl
    import conv_pkg::*;
#(
    parameter int DIM_W = CONV_DIM_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    samp_ctrl_if.master      bus,
    output logic             busy,
    output logic             done
`ifdef SAMP_CTRL_PERF_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [DIM_W-1:0] KERN      = DIM_W'(CONV_KERNEL);
    localparam logic [DIM_W-1:0] FILL_LAST = DIM_W'(CONV_KERNEL - 1);

    samp_ctrl_state_t state, next_state;

    logic [DIM_W-1:0] w_q, h_q;
    logic [DIM_W-1:0] row, col;
    logic             last_col, last_row;
    logic             cnt_clear, cnt_inc;
    logic             start_ok;

    // A start only counts while idle; it also latches the dimensions.
    assign start_ok = (state == IDLE) && start;

    scan_cnt #(
        .DIM_W (DIM_W)
    ) u_scan_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .w        (w_q),
        .h        (h_q),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_row (last_row)
    );

    // Frame dimensions, held for the whole frame.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_q <= '0;
            h_q <= '0;
        end else if (start_ok) begin
            w_q <= img_width;
            h_q <= img_height;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, counter controls and outputs decoded from state.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        cnt_clear      = 1'b0;
        cnt_inc        = 1'b0;
        bus.col_rd_en  = 1'b0;
        bus.col_row    = '0;
        bus.col_col    = '0;
        bus.shift_en   = 1'b0;
        bus.samp_valid = 1'b0;
        bus.out_row    = '0;
        bus.out_col    = '0;
        busy           = (state != IDLE);
        done           = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    // A frame smaller than the kernel has no windows.
                    if ((img_width < KERN) || (img_height < KERN)) begin
                        next_state = DONE;
                    end else begin
                        next_state = FETCH;
                    end
                end
            end

            FETCH: begin
                bus.col_rd_en = 1'b1;
                bus.col_row   = row;
                bus.col_col   = col;
                bus.shift_en  = bus.col_rd_valid;
                if (bus.col_rd_valid) begin
                    // The first two columns of a row only fill the window.
                    if (col < FILL_LAST) begin
                        cnt_inc = 1'b1;
                    end else begin
                        next_state = PRESENT;
                    end
                end
            end

            PRESENT: begin
                bus.samp_valid = 1'b1;
                bus.out_row    = row;
                bus.out_col    = col - FILL_LAST;
                if (bus.samp_ready) begin
                    if (last_col && last_row) begin
                        next_state = DONE;
                    end else begin
                        // Either the next column, or a wrap to a new row
                        // that refills the window from column 0.
                        cnt_inc    = 1'b1;
                        next_state = FETCH;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef SAMP_CTRL_PERF_EN
    logic stall_cycle;

    assign stall_cycle = ((state == PRESENT) && !bus.samp_ready) ||
                         ((state == FETCH)   && !bus.col_rd_valid);

    // Saturating count of cycles spent waiting on either neighbour.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (stall_cycle && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule : samp_ctrl

// File: tb/tb_samp_ctrl.sv
// Scoreboard bench for samp_ctrl: expected reads and windows are queued
// per frame, and a negedge monitor pops and compares them as the DUT
// completes each read or window handshake.
module tb_samp_ctrl;
    import conv_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] img_width = '0;
    logic [DW-1:0] img_height = '0;
    logic          rd_gate = 1'b1;
    logic          rdy = 1'b1;
    logic          busy;
    logic          done;
`ifdef SAMP_CTRL_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    samp_ctrl_if #(.DIM_W(DW)) bus ();

    // Read port answers whenever the gate is open (zero-wait when held high).
    assign bus.col_rd_valid = bus.col_rd_en & rd_gate;
    assign bus.samp_ready   = rdy;

    samp_ctrl #(
        .DIM_W (DW)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .img_width  (img_width),
        .img_height (img_height),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
`ifdef SAMP_CTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] rd_q[$];
    logic [15:0] win_q[$];

    int n_shift, n_rd_en, n_valid, n_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_col_rd_en"},  32'(bus.col_rd_en),  0);
        check({tag, "_col_row"},    32'(bus.col_row),    0);
        check({tag, "_col_col"},    32'(bus.col_col),    0);
        check({tag, "_shift_en"},   32'(bus.shift_en),   0);
        check({tag, "_samp_valid"}, 32'(bus.samp_valid), 0);
        check({tag, "_out_row"},    32'(bus.out_row),    0);
        check({tag, "_out_col"},    32'(bus.out_col),    0);
        check({tag, "_busy"},       32'(busy),           0);
        check({tag, "_done"},       32'(done),           0);
    endtask

    // Monitor: count strobes and score each completed read and window.
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.shift_en)   n_shift++;
            if (bus.col_rd_en)  n_rd_en++;
            if (bus.samp_valid) n_valid++;
            if (done)           n_done++;
            if (bus.col_rd_en && bus.col_rd_valid) begin
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL read_unexpected: got row=%0d col=%0d with nothing queued",
                             bus.col_row, bus.col_col);
                end else begin
                    check("read_addr", 32'({bus.col_row, bus.col_col}), 32'(rd_q.pop_front()));
                end
            end
            if (bus.samp_valid && bus.samp_ready) begin
                if (win_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL window_unexpected: got row=%0d col=%0d with nothing queued",
                             bus.out_row, bus.out_col);
                end else begin
                    check("window_pos", 32'({bus.out_row, bus.out_col}), 32'(win_q.pop_front()));
                end
            end
        end
    end

    // One frame: queue the expected reads/windows, pulse start, run to done.
    task automatic run_frame(input string tag, input int w, input int h,
                             input int exp_reads, input int exp_wins, input int exp_cycles,
                             input int stall, input bit mid_start, input bit slow);
        int cyc;
        int stall_left;
        if (w >= 3 && h >= 3) begin
            for (int r = 0; r <= h - 3; r++) begin
                for (int c = 0; c < w; c++) rd_q.push_back({8'(r), 8'(c)});
                for (int c = 0; c <= w - 3; c++) win_q.push_back({8'(r), 8'(c)});
            end
        end
        n_shift = 0; n_rd_en = 0; n_valid = 0; n_done = 0;
        stall_left = stall;
        rdy        = (stall == 0);
        rd_gate    = 1'b1;
        img_width  = 8'(w);
        img_height = 8'(h);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 3000) begin
            @(negedge clk);
            if (done) break;
            if (stall_left > 0 && bus.samp_valid) begin
                check({tag, "_stall_row"},   32'(bus.out_row),   0);
                check({tag, "_stall_col"},   32'(bus.out_col),   0);
                check({tag, "_stall_rd_en"}, 32'(bus.col_rd_en), 0);
                check({tag, "_stall_shift"}, 32'(bus.shift_en),  0);
                stall_left--;
            end
            @(posedge clk); #1;
            cyc++;
            if (stall > 0 && stall_left == 0) rdy = 1'b1;
            if (slow) rd_gate = cyc[0];
            if (mid_start && cyc == 4) begin
                img_width = 8'd9;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (cyc >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", tag, cyc);
        end
        if (exp_cycles > 0) check({tag, "_cycles"}, 32'(cyc + 1), 32'(exp_cycles));
        @(posedge clk); #1;
        rdy     = 1'b1;
        rd_gate = 1'b1;
        @(negedge clk);
        check({tag, "_idle_after"}, 32'(busy),    0);
        check({tag, "_done_count"}, 32'(n_done),  1);
        check({tag, "_shifts"},     32'(n_shift), 32'(exp_reads));
        if (!slow)       check({tag, "_rd_en_cycles"}, 32'(n_rd_en), 32'(exp_reads));
        if (stall == 0)  check({tag, "_valid_cycles"}, 32'(n_valid), 32'(exp_wins));
        check({tag, "_reads_left"},   32'(rd_q.size()),  0);
        check({tag, "_windows_left"}, 32'(win_q.size()), 0);
        rd_q.delete();
        win_q.delete();
    endtask

    initial begin
        int guard;
        // Reset state.
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("post_reset");

        // 4x3: 4 shifts, windows (0,0),(0,1), 8 cycles start..done.
        run_frame("w4h3", 4, 3, 4, 2, 8, 0, 1'b0, 1'b0);
`ifdef SAMP_CTRL_PERF_EN
        check("w4h3_stall_cnt", 32'(stall_cnt), 0);
`endif
        // 5x4: 10 reads over two rows, 6 windows, 18 cycles.
        run_frame("w5h4", 5, 4, 10, 6, 18, 0, 1'b0, 1'b0);
        // 4x3 with the first window held 5 cycles: 8 + 5 cycles.
        run_frame("stall", 4, 3, 4, 2, 13, 5, 1'b0, 1'b0);
`ifdef SAMP_CTRL_PERF_EN
        check("stall_stall_cnt", 32'(stall_cnt), 5);
`endif
        // Width below the kernel: straight to done, no reads or windows.
        run_frame("w2h10", 2, 10, 0, 0, 2, 0, 1'b0, 1'b0);
        // Start with w=9 mid-frame must not disturb the 5x4 frame.
        run_frame("midstart", 5, 4, 10, 6, 18, 0, 1'b1, 1'b0);
        // Read port answering only every other cycle.
        run_frame("slow", 3, 4, 6, 2, 0, 0, 1'b0, 1'b1);

        // Reset while a window is presented.
        rd_q.push_back(16'h0000);
        rd_q.push_back(16'h0001);
        rd_q.push_back(16'h0002);
        rdy        = 1'b0;
        img_width  = 8'd4;
        img_height = 8'd4;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.samp_valid && guard < 100);
        check("rst_reached_present", 32'(bus.samp_valid), 1);
        #2;
        n_rst = 1'b0;
        #1;
        check_zero_outputs("rst_mid");
        @(negedge clk);
        check_zero_outputs("rst_held");
        check("rst_reads_left", 32'(rd_q.size()), 0);
        rd_q.delete();
        win_q.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;
        rdy   = 1'b1;
        // 3x3 after reset: one window at (0,0), 6 cycles.
        run_frame("after_rst", 3, 3, 3, 1, 6, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_samp_ctrl
